// File: rtl/area_scan_seq.sv
// Scan sequencer: runs up to N_AREA area scanners one at a time with start/done/error
// handshakes, a one-hot bus grant, per-area watchdog abort and latched error/timeout maps.
module area_scan_seq #(
    parameter int N_AREA  = 4,
    parameter int BASE_W  = 12,
    parameter int TMO_W   = 16,
    parameter int TMO_CYC = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start_con,
    input  logic [BASE_W-1:0] im_base_addr,
    input  logic [N_AREA-1:0] im_area_en,
    input  logic              i_stop_on_err,
    output logic              o_done_con,
    output logic              o_error_con,
    output logic              o_busy,
    output logic [BASE_W-1:0] om_base_addr,
    output logic [N_AREA-1:0] om_start,
    output logic [N_AREA-1:0] om_abort,
    input  logic [N_AREA-1:0] i_done,
    input  logic [N_AREA-1:0] i_error,
    output logic [N_AREA-1:0] om_grant,
    output logic [3:0]        om_cur_area,
    output logic [N_AREA-1:0] om_err_map,
    output logic [N_AREA-1:0] om_tmo_map
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_LAUNCH,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [4:0]        r_idx, w_idx_nxt;
    logic [N_AREA-1:0] r_area_en;
    logic              r_stop_on_err;
    logic [BASE_W-1:0] r_base_addr;
    logic [TMO_W-1:0]  r_timer;
    logic [N_AREA-1:0] r_err_map, w_err_map_nxt;
    logic [N_AREA-1:0] r_tmo_map, w_tmo_map_nxt;
    logic [N_AREA-1:0] r_start, w_start_nxt;
    logic [N_AREA-1:0] r_abort, w_abort_nxt;
    logic              r_done_con, w_done_nxt;
    logic              r_error_con, w_err_con_nxt;
    logic              r_busy;
    logic [3:0]        r_cur_area;

    logic [N_AREA-1:0] w_cur_oh;
    logic              w_found;
    logic [4:0]        w_sel_idx;
    logic              w_hit_done, w_hit_err, w_tmo;

    // idx can reach N_AREA after the last area; the shift then yields an all-zero mask.
    assign w_cur_oh   = N_AREA'(1) << r_idx;
    assign w_hit_done = |(i_done & w_cur_oh);
    assign w_hit_err  = |(i_error & w_cur_oh);
    assign w_tmo      = (r_timer == TMO_W'(TMO_CYC - 1)) && !w_hit_done && !w_hit_err;

    // Lowest enabled area at or above idx: scan downwards so the lowest match is written last.
    always_comb begin
        w_found   = 1'b0;
        w_sel_idx = '0;
        for (int k = N_AREA - 1; k >= 0; k--) begin
            if (r_area_en[k] && (5'(k) >= r_idx)) begin
                w_found   = 1'b1;
                w_sel_idx = 5'(k);
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_err_map_nxt = r_err_map;
        w_tmo_map_nxt = r_tmo_map;
        w_start_nxt   = '0;
        w_abort_nxt   = '0;
        case (r_state)
            S_IDLE: begin
                if (i_start_con) begin
                    w_state_nxt   = S_SEL;
                    w_idx_nxt     = '0;
                    w_err_map_nxt = '0;
                    w_tmo_map_nxt = '0;
                end
            end
            S_SEL: begin
                if (w_found) begin
                    w_state_nxt = S_LAUNCH;
                    w_idx_nxt   = w_sel_idx;
                    w_start_nxt = N_AREA'(1) << w_sel_idx;
                end else begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_LAUNCH: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_hit_done || w_hit_err || w_tmo) begin
                    if (w_hit_err || w_tmo) w_err_map_nxt = r_err_map | w_cur_oh;
                    if (w_tmo) begin
                        w_tmo_map_nxt = r_tmo_map | w_cur_oh;
                        w_abort_nxt   = w_cur_oh;
                    end
                    if ((w_hit_err || w_tmo) && r_stop_on_err) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_state_nxt = S_SEL;
                        w_idx_nxt   = r_idx + 5'd1;
                    end
                end
            end
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        // FINISH always exits after one cycle, so entering it is the only way next==FINISH.
        w_done_nxt    = (w_state_nxt == S_FINISH);
        w_err_con_nxt = w_done_nxt && (|w_err_map_nxt);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx         <= '0;
            r_area_en     <= '0;
            r_stop_on_err <= 1'b0;
            r_base_addr   <= '0;
            r_timer       <= '0;
            r_err_map     <= '0;
            r_tmo_map     <= '0;
            r_start       <= '0;
            r_abort       <= '0;
            r_done_con    <= 1'b0;
            r_error_con   <= 1'b0;
            r_busy        <= 1'b0;
            r_cur_area    <= '0;
        end else begin
            r_idx       <= w_idx_nxt;
            r_err_map   <= w_err_map_nxt;
            r_tmo_map   <= w_tmo_map_nxt;
            r_start     <= w_start_nxt;
            r_abort     <= w_abort_nxt;
            r_done_con  <= w_done_nxt;
            r_error_con <= w_err_con_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            if (r_state == S_IDLE && i_start_con) begin
                r_base_addr   <= im_base_addr;
                r_area_en     <= im_area_en;
                r_stop_on_err <= i_stop_on_err;
            end
            // Timer is zero during LAUNCH, so the watchdog window spans TMO_CYC granted cycles.
            if (r_state == S_SEL)
                r_timer <= '0;
            else if (r_state == S_LAUNCH || r_state == S_WAIT)
                r_timer <= r_timer + TMO_W'(1);
            if (w_state_nxt == S_IDLE)
                r_cur_area <= '0;
            else if (r_state == S_SEL && w_found)
                r_cur_area <= w_sel_idx[3:0];
        end
    end

    assign om_grant     = (r_state == S_LAUNCH || r_state == S_WAIT) ? w_cur_oh : '0;
    assign om_start     = r_start;
    assign om_abort     = r_abort;
    assign o_done_con   = r_done_con;
    assign o_error_con  = r_error_con;
    assign o_busy       = r_busy;
    assign om_base_addr = r_base_addr;
    assign om_cur_area  = r_cur_area;
    assign om_err_map   = r_err_map;
    assign om_tmo_map   = r_tmo_map;

endmodule
